msk_aes128_ks_ctrl: RTL and testbench

- Sequencer and state holder for the masked AES-128 key schedule. Sits directly upstream of the masked key-schedule round datapath (4 masked S-boxes, LATENCY-cycle pipeline).
- Accepts a masked 128-bit key, holds the masked key state, and launches one KS round at a time. It generates the masked RCON, captures each round result and streams round keys 0..10 to the cipher datapath over a valid/ready handshake.

---
 rtl/msk_aes128_ks_ctrl.sv | 151 +++++++++++++++
 tb/tb_msk_aes128_ks_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msk_aes128_ks_ctrl.sv
// msk_aes128_ks_ctrl: sequencer and masked key-state holder for the AES-128
// key schedule. Loads a masked key, launches one round at a time on the
// external masked round datapath, injects the masked RCON on the round's
// final cycle and streams round keys 0..10 over valid/ready.
// Shares are never combined here.
// Optional build macro MSK_KS_LAST_KEY_OUT_EN adds rk_last/rk_last_valid,
// which hold round key 10 as the decryption starting key.
module msk_aes128_ks_ctrl #(
  parameter int d       = 2,
  parameter int LATENCY = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_valid,
  output logic               key_ready,
  input  logic [128*d-1:0]   sh_key,
  output logic [128*d-1:0]   ks_key_to_round,
  input  logic [128*d-1:0]   ks_key_from_round,
  output logic [8*d-1:0]     ks_rcon,
  output logic               ks_busy,
  output logic [128*d-1:0]   rk,
  output logic [3:0]         rk_idx,
  output logic               rk_valid,
`ifdef MSK_KS_LAST_KEY_OUT_EN
  output logic [128*d-1:0]   rk_last,
  output logic               rk_last_valid,
`endif
  input  logic               rk_ready
);

  localparam int KW    = 128 * d;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OUT   = 2'd1,
    ROUND = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    key_q;
  logic [7:0]       rcon_q;
  logic [3:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             load_key;
  logic             launch;
  logic             capture;

  // GF(2^8) doubling used to step RCON from one round to the next
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, handshake outputs and datapath strobes
  always_comb begin
    state_d   = state_q;
    key_ready = 1'b0;
    rk_valid  = 1'b0;
    ks_busy   = 1'b0;
    load_key  = 1'b0;
    launch    = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          load_key = 1'b1;
          state_d  = OUT;
        end
      end
      OUT: begin
        rk_valid = 1'b1;
        if (rk_ready) begin
          if (idx_q == 4'd10) begin
            state_d = IDLE;
          end else begin
            launch  = 1'b1;
            state_d = ROUND;
          end
        end
      end
      ROUND: begin
        ks_busy = 1'b1;
        if (cnt_q == CNT_LAST) begin
          capture = 1'b1;
          state_d = OUT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Masked RCON: plain value on share 0 during the capture cycle only
  always_comb begin
    ks_rcon = '0;
    if (capture) begin
      for (int b = 0; b < 8; b++) begin
        ks_rcon[b*d] = rcon_q[b];
      end
    end
  end

  // Key state, round index, RCON and in-round cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q  <= '0;
      idx_q  <= '0;
      rcon_q <= 8'h01;
      cnt_q  <= '0;
    end else begin
      if (load_key) begin
        key_q  <= sh_key;
        idx_q  <= 4'd0;
        rcon_q <= 8'h01;
      end else if (capture) begin
        key_q  <= ks_key_from_round;
        idx_q  <= idx_q + 4'd1;
        rcon_q <= xtime(rcon_q);
      end
      if (launch)       cnt_q <= '0;
      else if (ks_busy) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign ks_key_to_round = key_q;
  assign rk              = key_q;
  assign rk_idx          = idx_q;

`ifdef MSK_KS_LAST_KEY_OUT_EN
  // Round key 10 retained until the next key load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_last       <= '0;
      rk_last_valid <= 1'b0;
    end else if (load_key) begin
      rk_last_valid <= 1'b0;
    end else if (capture && (idx_q == 4'd9)) begin
      rk_last       <= ks_key_from_round;
      rk_last_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_msk_aes128_ks_ctrl.sv
// Bench for msk_aes128_ks_ctrl: behavioural masked round datapath, stimulus
// that pushes expected round keys / RCONs into queues, and a monitor that
// pops and compares on every rk handshake and every nonzero ks_rcon cycle.
module tb_msk_aes128_ks_ctrl;

  localparam int D   = 2;
  localparam int LAT = 6;

  logic             clk;
  logic             rst_n;
  logic             key_valid;
  logic             key_ready;
  logic [128*D-1:0] sh_key;
  logic [128*D-1:0] ks_key_to_round;
  logic [128*D-1:0] ks_key_from_round;
  logic [8*D-1:0]   ks_rcon;
  logic             ks_busy;
  logic [128*D-1:0] rk;
  logic [3:0]       rk_idx;
  logic             rk_valid;
  logic             rk_ready;
`ifdef MSK_KS_LAST_KEY_OUT_EN
  logic [128*D-1:0] rk_last;
  logic             rk_last_valid;
`endif

  msk_aes128_ks_ctrl #(.d(D), .LATENCY(LAT)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .key_valid         (key_valid),
    .key_ready         (key_ready),
    .sh_key            (sh_key),
    .ks_key_to_round   (ks_key_to_round),
    .ks_key_from_round (ks_key_from_round),
    .ks_rcon           (ks_rcon),
    .ks_busy           (ks_busy),
    .rk                (rk),
    .rk_idx            (rk_idx),
    .rk_valid          (rk_valid),
`ifdef MSK_KS_LAST_KEY_OUT_EN
    .rk_last           (rk_last),
    .rk_last_valid     (rk_last_valid),
`endif
    .rk_ready          (rk_ready)
  );

  // FIPS-197 A.1 key (set 0) and C.1 key 000102..0f (set 1), round keys 0..10
  logic [127:0] rk_tab [2][11] = '{
    '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6},
    '{128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
      128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
      128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
      128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
      128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
      128'h13111d7fe3944a17f307a78b4d2b30c5}
  };
  logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  exp_t       exp_q [$];
  logic [7:0] rc_q [$];
  int         n_checks = 0;
  int         n_err    = 0;
  int         hs_count = 0;
  int         cyc      = 0;
  logic [127:0] dp_mask = '0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    for (int c = 1; c < 256; c++) begin
      if (gmul(a, 8'(c)) == 8'h01) inv = 8'(c);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  // Byte i of the big-endian key is byte i of the share layout
  function automatic logic [255:0] mask_key(input logic [127:0] k, input logic [127:0] m);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      for (int b = 0; b < 8; b++) begin
        r[2*(8*i+b)]   = k[120-8*i+b] ^ m[8*i+b];
        r[2*(8*i+b)+1] = m[8*i+b];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] unmask(input logic [255:0] v);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      for (int b = 0; b < 8; b++) begin
        r[120-8*i+b] = v[2*(8*i+b)] ^ v[2*(8*i+b)+1];
      end
    end
    return r;
  endfunction

  // Behavioural masked round: unmask, one AES-128 expansion step, remask
  function automatic logic [255:0] dp_model(input logic [255:0] kin, input logic [15:0] rc_sh,
                                            input logic [127:0] m);
    logic [127:0] k;
    logic [7:0]   rc;
    logic [31:0]  w0, w1, w2, w3, t;
    k = unmask(kin);
    for (int b = 0; b < 8; b++) rc[b] = rc_sh[2*b] ^ rc_sh[2*b+1];
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return mask_key({w0, w1, w2, w3}, m);
  endfunction

  assign ks_key_from_round = dp_model(ks_key_to_round, ks_rcon, dp_mask);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      dp_mask = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: pops expectations on rk handshakes and RCON cycles, checks timing
  initial begin : monitor
    logic [255:0] stall_rk;
    logic [3:0]   stall_idx;
    logic         in_stall, prev_valid, post_hs, post_last;
    logic [7:0]   s0, s1;
    int           rc_cnt, last_ev;
    exp_t         e;
    in_stall = 1'b0; prev_valid = 1'b0; post_hs = 1'b0; post_last = 1'b0;
    rc_cnt = 0; last_ev = 0; stall_rk = '0; stall_idx = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_stall = 1'b0; prev_valid = 1'b0; post_hs = 1'b0; rc_cnt = 0;
      end else begin
        if (post_hs) begin
          if (post_last) chki("idle_return", int'(key_ready), 1);
          else           chki("launch_busy", int'(ks_busy), 1);
          post_hs = 1'b0;
        end
        if (key_valid && key_ready) last_ev = cyc;
        if (rk_valid && !prev_valid) begin
          chki("rk_latency", cyc - last_ev, (rk_idx == 4'd0) ? 1 : LAT + 1);
          if (rk_idx != 4'd0) chki("rcon_once", rc_cnt, 1);
          rc_cnt = 0;
`ifdef MSK_KS_LAST_KEY_OUT_EN
          chki("rk_last_valid", int'(rk_last_valid), (rk_idx == 4'd10) ? 1 : 0);
          if (rk_idx == 4'd10) chk("rk_last", 256'(unmask(rk_last)), 256'(unmask(rk)));
`endif
        end
        if (rk_valid && !rk_ready) begin
          if (in_stall) begin
            chk("stall_rk", rk, stall_rk);
            chki("stall_idx", int'(rk_idx), int'(stall_idx));
            chki("stall_busy", int'(ks_busy), 0);
          end else begin
            in_stall  = 1'b1;
            stall_rk  = rk;
            stall_idx = rk_idx;
          end
        end
        if (rk_valid && rk_ready) begin
          if (exp_q.size() == 0) begin
            fail("rk_unexpected");
          end else begin
            e = exp_q.pop_front();
            chki("rk_idx", int'(rk_idx), int'(e.idx));
            chk("rk_value", 256'(unmask(rk)), 256'(e.key));
          end
          last_ev   = cyc;
          post_hs   = 1'b1;
          post_last = (rk_idx == 4'd10);
          in_stall  = 1'b0;
          hs_count++;
        end
        if (ks_rcon != '0) begin
          rc_cnt++;
          chki("rcon_busy", int'(ks_busy), 1);
          for (int b = 0; b < 8; b++) begin
            s0[b] = ks_rcon[2*b];
            s1[b] = ks_rcon[2*b+1];
          end
          if (rc_q.size() == 0) fail("rcon_unexpected");
          else                  chki("rcon_share0", int'(s0), int'(rc_q.pop_front()));
          chki("rcon_share1", int'(s1), 0);
        end
        prev_valid = rk_valid;
      end
    end
  end

  task automatic check_reset_state();
    chki("rst_key_ready", int'(key_ready), 1);
    chki("rst_rk_valid", int'(rk_valid), 0);
    chki("rst_ks_busy", int'(ks_busy), 0);
    chki("rst_rk_idx", int'(rk_idx), 0);
    chk("rst_ks_rcon", 256'(ks_rcon), '0);
    chk("rst_key_reg", ks_key_to_round, '0);
`ifdef MSK_KS_LAST_KEY_OUT_EN
    chki("rst_rk_last_valid", int'(rk_last_valid), 0);
`endif
  endtask

  // Called while the controller is idle, just after a clock edge
  task automatic issue_key(input int w);
    exp_t e;
    for (int i = 0; i < 11; i++) begin
      e.idx = 4'(i);
      e.key = rk_tab[w][i];
      exp_q.push_back(e);
    end
    for (int i = 0; i < 10; i++) rc_q.push_back(rcon_tab[i]);
    sh_key    = mask_key(rk_tab[w][0], {$urandom(), $urandom(), $urandom(), $urandom()});
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic wait_hs(input int n);
    int t;
    t = 0;
    while (hs_count < n && t < 400) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (hs_count < n) fail("hs_timeout");
  endtask

  initial begin : stimulus
    int base;
    int t;
    rst_n = 1'b0; key_valid = 1'b0; sh_key = '0; rk_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full schedule, rk_ready held high, stray key_valid while busy
    base = hs_count;
    issue_key(0);
    sh_key    = mask_key(128'hdeadbeef_01234567_89abcdef_55aa55aa, {$urandom(), $urandom(), $urandom(), $urandom()});
    key_valid = 1'b1;
    wait_hs(base + 5);
    key_valid = 1'b0;
    wait_hs(base + 11);
    repeat (2) @(posedge clk);
    #1;
`ifdef MSK_KS_LAST_KEY_OUT_EN
    chki("last_valid_end", int'(rk_last_valid), 1);
    chk("last_value_end", 256'(unmask(rk_last)), 256'(rk_tab[0][10]));
`endif

    // Backpressure on round key 3 for 20 cycles
    base = hs_count;
    issue_key(0);
`ifdef MSK_KS_LAST_KEY_OUT_EN
    chki("last_valid_cleared", int'(rk_last_valid), 0);
`endif
    wait_hs(base + 3);
    rk_ready = 1'b0;
    t = 0;
    while (!(rk_valid && rk_idx == 4'd3) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) fail("stall_wait_timeout");
    repeat (20) @(posedge clk);
    #1;
    rk_ready = 1'b1;
    wait_hs(base + 11);
    repeat (2) @(posedge clk);
    #1;

    // Reset during round 5, then a different key
    base = hs_count;
    issue_key(0);
    wait_hs(base + 6);
    @(posedge clk); #1;
    chki("in_round5", int'(ks_busy), 1);
    rst_n = 1'b0;
    exp_q.delete();
    rc_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset_state();
    base = hs_count;
    issue_key(1);
    wait_hs(base + 11);
    repeat (3) @(posedge clk);
    #1;
`ifdef MSK_KS_LAST_KEY_OUT_EN
    chk("last_value_key2", 256'(unmask(rk_last)), 256'(rk_tab[1][10]));
`endif

    chki("exp_q_drained", exp_q.size(), 0);
    chki("rc_q_drained", rc_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
